// File: rtl/mem_rw_sched_pkg.sv
// Shared types for the checkpoint-replay memory scheduler.
//   state_e    : scheduler FSM states
//   mem_cmd_t  : one latched command (write flag, index, data, mask, owner id, range error)
//   DEFAULT_MAX_INDEX : first illegal 64-bit word index (4 GiB / 8)
package mem_rw_sched_pkg;

    // Wide enough for the largest supported requester count (8).
    localparam int ID_W = 3;

    localparam logic [63:0] DEFAULT_MAX_INDEX = 64'h2000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic            write;
        logic [63:0]     index;
        logic [63:0]     wdata;
        logic [63:0]     wmask;
        logic [ID_W-1:0] id;
        logic            err;
    } mem_cmd_t;

    function automatic logic index_illegal(input logic [63:0] index,
                                           input logic [63:0] max_index);
        return index >= max_index;
    endfunction

endpackage

// File: rtl/mem_rw_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector, one bit per requester
//   ptr    : highest-priority requester this round
//   grant  : one-hot grant (all zero when nothing requests)
//   winner : binary index of the granted requester (0 when nothing requests)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk from ptr upward with wrap; the first requester seen wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr) + off) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/mem_rw_sched.sv
// Round-robin scheduler sharing one MemRWHelper read/write port pair among
// NUM_REQ requesters. One command is in flight at a time:
// accept (IDLE) -> one-cycle helper strobe (ISSUE) -> response handshake (RESP).
// Ports:
//   clock, reset_n                 : clock, async active-low reset
//   req_valid/ready/write          : per-requester command handshake and direction
//   req_index/wdata/wmask          : per-requester 64-bit fields, requester i at [64i+63:64i]
//   resp_valid/ready               : per-requester response handshake
//   resp_rdata/write/err           : shared response payload
//   mem_enable                     : helper global enable
//   mem_r_enable/index, mem_r_data : helper read port (data registered by helper)
//   mem_w_enable/index/data/mask   : helper write port
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrating; req_ready driven to the round-robin winner
// ISSUE | helper strobe high this cycle (suppressed on a range error)
// RESP  | response held to the owner until its resp_ready
module mem_rw_sched
    import mem_rw_sched_pkg::*;
#(
    parameter int          NUM_REQ   = 4,
    parameter logic [63:0] MAX_INDEX = DEFAULT_MAX_INDEX
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*64-1:0] req_index,
    input  logic [NUM_REQ*64-1:0] req_wdata,
    input  logic [NUM_REQ*64-1:0] req_wmask,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [63:0]           resp_rdata,
    output logic                  resp_write,
    output logic                  resp_err,
    output logic                  mem_enable,
    output logic                  mem_r_enable,
    output logic [63:0]           mem_r_index,
    input  logic [63:0]           mem_r_data,
    output logic                  mem_w_enable,
    output logic [63:0]           mem_w_index,
    output logic [63:0]           mem_w_data,
    output logic [63:0]           mem_w_mask
);

    localparam int PW = $clog2(NUM_REQ);

    state_e               state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        ptr_next;
    logic [NUM_REQ-1:0]   grant;
    logic [PW-1:0]        winner;
    mem_cmd_t             cmd;
    mem_cmd_t             next_cmd;
    logic [NUM_REQ-1:0]   id_onehot;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    always_comb begin
        next_cmd       = '0;
        next_cmd.write = req_write[winner];
        next_cmd.index = req_index[int'(winner)*64 +: 64];
        next_cmd.wdata = req_wdata[int'(winner)*64 +: 64];
        next_cmd.wmask = req_wmask[int'(winner)*64 +: 64];
        next_cmd.id    = ID_W'(winner);
        next_cmd.err   = index_illegal(next_cmd.index, MAX_INDEX);
    end

    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            id_onehot[i] = (cmd.id == ID_W'(i));
        end
    end

    assign ptr_next = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);

    // Gated by reset_n so ready is low while held in reset even if requests are up.
    assign req_ready  = (state == IDLE && reset_n) ? grant : '0;
    assign mem_enable = reset_n;

    // The helper's read data stays put in RESP because no read is issued there.
    assign resp_rdata = (state == RESP && !cmd.write && !cmd.err) ? mem_r_data : '0;

    assign mem_r_index = cmd.index;
    assign mem_w_index = cmd.index;
    assign mem_w_data  = cmd.wdata;
    assign mem_w_mask  = cmd.wmask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cmd          <= '0;
            mem_r_enable <= 1'b0;
            mem_w_enable <= 1'b0;
            resp_valid   <= '0;
            resp_write   <= 1'b0;
            resp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        cmd          <= next_cmd;
                        rr_ptr       <= ptr_next;
                        mem_r_enable <= !next_cmd.write && !next_cmd.err;
                        mem_w_enable <= next_cmd.write && !next_cmd.err;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_r_enable <= 1'b0;
                    mem_w_enable <= 1'b0;
                    resp_valid   <= id_onehot;
                    resp_write   <= cmd.write;
                    resp_err     <= cmd.err;
                    state        <= RESP;
                end
                RESP: begin
                    // resp_valid is one-hot on the owner, so this ignores other requesters.
                    if (|(resp_ready & resp_valid)) begin
                        resp_valid <= '0;
                        resp_write <= 1'b0;
                        resp_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rw_sched.sv
module tb_mem_rw_sched;

    logic         clock;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_write;
    logic [255:0] req_index;
    logic [255:0] req_wdata;
    logic [255:0] req_wmask;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [63:0]  resp_rdata;
    logic         resp_write;
    logic         resp_err;
    logic         mem_enable;
    logic         mem_r_enable;
    logic [63:0]  mem_r_index;
    logic [63:0]  mem_r_data;
    logic         mem_w_enable;
    logic [63:0]  mem_w_index;
    logic [63:0]  mem_w_data;
    logic [63:0]  mem_w_mask;

    mem_rw_sched #(
        .NUM_REQ   (4),
        .MAX_INDEX (64'h2000_0000)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_index    (req_index),
        .req_wdata    (req_wdata),
        .req_wmask    (req_wmask),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_write   (resp_write),
        .resp_err     (resp_err),
        .mem_enable   (mem_enable),
        .mem_r_enable (mem_r_enable),
        .mem_r_index  (mem_r_index),
        .mem_r_data   (mem_r_data),
        .mem_w_enable (mem_w_enable),
        .mem_w_index  (mem_w_index),
        .mem_w_data   (mem_w_data),
        .mem_w_mask   (mem_w_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] model(input logic [63:0] idx);
        return (idx == 64'h10) ? 64'hDEAD_BEEF : {32'h1234_5678, idx[31:0]};
    endfunction

    // Helper read port: data registered one cycle after the strobe.
    initial mem_r_data = '0;
    always @(posedge clock) begin
        if (mem_r_enable) mem_r_data <= model(mem_r_index);
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [3:0]  oh;
        logic        write;
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    task automatic check_resp();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL resp_unexpected: got resp_valid %b expected no response", resp_valid);
            return;
        end
        e = exp_q.pop_front();
        chk("resp_valid", resp_valid, e.oh);
        chk("resp_write", resp_write, e.write);
        chk("resp_err",   resp_err,   e.err);
        chk("resp_rdata", resp_rdata, e.rdata);
    endtask

    typedef struct {
        int          id;
        logic        write;
        logic [63:0] index;
        logic [63:0] wdata;
        logic [63:0] wmask;
        int          bp;
        logic        exp_rd;
        logic        exp_wr;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic run_cmd(input vec_t v);
        logic [3:0] oh;
        exp_t e;
        oh      = 4'b0001 << v.id;
        e.oh    = oh;
        e.write = v.write;
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        exp_q.push_back(e);

        @(negedge clock);
        req_index[64*v.id +: 64] = v.index;
        req_wdata[64*v.id +: 64] = v.wdata;
        req_wmask[64*v.id +: 64] = v.wmask;
        req_write[v.id]          = v.write;
        req_valid                = oh;
        resp_ready               = (v.bp > 0) ? ~oh : 4'hF;
        #1;
        chk("accept_ready", req_ready, oh);
        chk("accept_no_strobe", {mem_r_enable, mem_w_enable}, 2'b00);

        @(posedge clock);
        #1;
        // Scramble the request after acceptance; the DUT must use its latched copy.
        req_valid                = '0;
        req_index[64*v.id +: 64] = '1;
        req_wdata[64*v.id +: 64] = '0;
        req_wmask[64*v.id +: 64] = '0;
        req_write[v.id]          = ~v.write;

        @(negedge clock);
        chk("issue_r_en", mem_r_enable, v.exp_rd);
        chk("issue_w_en", mem_w_enable, v.exp_wr);
        chk("issue_req_ready", req_ready, 4'b0000);
        chk("issue_resp_valid", resp_valid, 4'b0000);
        if (v.exp_rd) chk("issue_r_index", mem_r_index, v.index);
        if (v.exp_wr) begin
            chk("issue_w_index", mem_w_index, v.index);
            chk("issue_w_data",  mem_w_data,  v.wdata);
            chk("issue_w_mask",  mem_w_mask,  v.wmask);
        end

        @(negedge clock);
        chk("strobe_one_cycle", {mem_r_enable, mem_w_enable}, 2'b00);
        for (int k = 0; k < v.bp; k++) begin
            chk("bp_resp_valid", resp_valid, oh);
            chk("bp_resp_rdata", resp_rdata, v.exp_rdata);
            chk("bp_req_ready",  req_ready,  4'b0000);
            chk("bp_strobes", {mem_r_enable, mem_w_enable}, 2'b00);
            @(negedge clock);
        end
        resp_ready = 4'hF;
        check_resp();
        @(negedge clock);
        chk("idle_after_resp", resp_valid, 4'b0000);
    endtask

    task automatic stream(input logic [3:0] vmask, input logic [23:0] order, input int n);
        int got;
        int cyc;
        int last;
        exp_t e;
        got  = 0;
        cyc  = 0;
        last = 0;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            req_index[64*i +: 64] = 64'h100 + 64'(i);
            req_write[i]          = 1'b0;
        end
        req_valid  = vmask;
        resp_ready = 4'hF;
        #1;
        while (got < n && cyc < 60) begin
            if (|resp_valid) check_resp();
            if (|req_ready) begin
                chk("rr_grant", req_ready, order[4*got +: 4]);
                if (got > 0) chk("rr_spacing", 64'(cyc - last), 64'd3);
                e.oh    = order[4*got +: 4];
                e.write = 1'b0;
                e.err   = 1'b0;
                e.rdata = '0;
                for (int j = 0; j < 4; j++) begin
                    if (e.oh[j]) e.rdata = model(64'h100 + 64'(j));
                end
                exp_q.push_back(e);
                last = cyc;
                got++;
            end
            if (got < n) begin
                @(negedge clock);
                #1;
                cyc++;
            end
        end
        if (got < n) begin
            n_total++;
            $display("FAIL rr_timeout: got %0d grants expected %0d", got, n);
        end
        @(posedge clock);
        #1;
        req_valid = '0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clock);
            #1;
            if (|resp_valid) check_resp();
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL resp_missing: got %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        // id, write, index, wdata, wmask, bp, exp_rd, exp_wr, exp_err, exp_rdata
        vecs[0] = '{0, 1'b0, 64'h10,          64'h0,                   64'h0,                   0, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF};
        vecs[1] = '{1, 1'b1, 64'h5,           64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF,                0, 1'b0, 1'b1, 1'b0, 64'h0};
        vecs[2] = '{2, 1'b0, 64'h20,          64'h0,                   64'h0,                   5, 1'b1, 1'b0, 1'b0, 64'h1234_5678_0000_0020};
        vecs[3] = '{3, 1'b0, 64'h2000_0000,   64'h0,                   64'h0,                   0, 1'b0, 1'b0, 1'b1, 64'h0};
        vecs[4] = '{0, 1'b0, 64'h1FFF_FFFF,   64'h0,                   64'h0,                   0, 1'b1, 1'b0, 1'b0, 64'h1234_5678_1FFF_FFFF};
        vecs[5] = '{2, 1'b1, 64'h2000_0001,   64'hAAAA,                64'hF,                   0, 1'b0, 1'b0, 1'b1, 64'h0};
        vecs[6] = '{3, 1'b1, 64'h1FFF_FFFF,   64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 0, 1'b0, 1'b1, 1'b0, 64'h0};

        reset_n    = 1'b0;
        req_valid  = 4'hF;
        req_write  = '0;
        req_index  = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        resp_ready = '0;

        #12;
        chk("rst_req_ready",  req_ready,  4'b0000);
        chk("rst_resp_valid", resp_valid, 4'b0000);
        chk("rst_resp_rdata", resp_rdata, 64'h0);
        chk("rst_resp_flags", {resp_write, resp_err}, 2'b00);
        chk("rst_strobes",    {mem_r_enable, mem_w_enable}, 2'b00);
        chk("rst_mem_enable", mem_enable, 1'b0);
        chk("rst_r_index",    mem_r_index, 64'h0);
        chk("rst_w_fields",   mem_w_index | mem_w_data | mem_w_mask, 64'h0);
        req_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("mem_enable_run", mem_enable, 1'b1);
        chk("idle_no_ready",  req_ready,  4'b0000);

        for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

        // Fairness from a fresh pointer: 0,1,2,3,0,1, one accept every 3 cycles.
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        stream(4'b1111, {4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001}, 6);

        // Reset during the ISSUE cycle of a write from requester 1.
        @(negedge clock);
        req_index[64 +: 64] = 64'h7;
        req_wdata[64 +: 64] = 64'h55;
        req_wmask[64 +: 64] = 64'hFF;
        req_write[1]        = 1'b1;
        req_valid           = 4'b0010;
        resp_ready          = 4'hF;
        #1;
        chk("rstmid_accept", req_ready, 4'b0010);
        @(posedge clock);
        #1;
        req_valid = '0;
        @(negedge clock);
        chk("rstmid_w_en_before", mem_w_enable, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rstmid_w_en_drop",  mem_w_enable, 1'b0);
        chk("rstmid_resp_valid", resp_valid,   4'b0000);
        chk("rstmid_mem_enable", mem_enable,   1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("rstmid_no_resp", resp_valid, 4'b0000);
            chk("rstmid_no_strobe", {mem_r_enable, mem_w_enable}, 2'b00);
        end
        // Pointer was 2 before reset; after reset requester 0 must win over 2.
        stream(4'b0101, {16'h0, 4'b0100, 4'b0001}, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
